// File: rtl/k_and_s_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | k_and_s_pkg : shared types and sizes for the K&S memory harness     |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
package k_and_s_pkg;

  localparam int MEM_DEPTH  = 32;
  localparam int MEM_ADDR_W = 5;
  localparam int MEM_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DUMP = 3'd3,
    DONE = 3'd4
  } mem_state_type;

endpackage
`default_nettype wire

// File: rtl/k_and_s_ram.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | k_and_s_ram : word storage, two async read ports, one sync write    |
// | Revision    : 1.0                                                   |
// +--------------------------------------------------------------------+
module k_and_s_ram #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] cpu_raddr,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic [ADDR_W-1:0] dump_raddr,
  output logic [DATA_W-1:0] dump_rdata
);

  // Contents survive rst on purpose: a reset mid-load keeps what was written.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign cpu_rdata  = mem[cpu_raddr];
  assign dump_rdata = mem[dump_raddr];

endmodule
`default_nettype wire

// File: rtl/k_and_s_memory.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | k_and_s_memory : K&S program/data memory with loader and dump FSM   |
// | Revision       : 1.0                                                |
// +--------------------------------------------------------------------+
module k_and_s_memory
  import k_and_s_pkg::*;
#(
  parameter int DEPTH      = MEM_DEPTH,
  parameter int ADDR_W     = MEM_ADDR_W,
  parameter int DATA_W     = MEM_DATA_W,
  parameter int MAX_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_valid,
  input  logic [7:0]        load_data,
  output logic              load_ready,
  output logic              cpu_rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_enable,
  input  logic              halt,
  output logic [DATA_W-1:0] data_out,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              done,
  output logic              timeout,
  output logic [15:0]       cycle_count
);

  localparam int BYTES = DATA_W / 8;
  localparam int PH_W  = (BYTES > 2) ? $clog2(BYTES) : 1;
  localparam logic [PH_W-1:0]   LAST_PH     = PH_W'(BYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
  localparam logic [15:0]       BUDGET_LAST = 16'(MAX_CYCLES - 1);

  mem_state_type     state;
  logic [ADDR_W-1:0] pointer;
  logic [PH_W-1:0]   phase;
  logic [DATA_W-9:0] lo_bytes;

  logic              load_accept;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;

  assign load_accept = load_valid & load_ready;
  assign dump_addr   = pointer;

  // The loader owns the write port in LOAD, the processor only in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = addr;
    ram_wdata = data_in;
    if (state == LOAD) begin
      ram_we    = load_accept && (phase == LAST_PH);
      ram_waddr = pointer;
      ram_wdata = {load_data, lo_bytes};
    end else if (state == RUN) begin
      ram_we    = write_enable;
    end
  end

  k_and_s_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk        (clk),
    .we         (ram_we),
    .waddr      (ram_waddr),
    .wdata      (ram_wdata),
    .cpu_raddr  (addr),
    .cpu_rdata  (data_out),
    .dump_raddr (pointer),
    .dump_rdata (dump_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pointer     <= '0;
      phase       <= '0;
      lo_bytes    <= '0;
      load_ready  <= 1'b0;
      cpu_rst_n   <= 1'b0;
      dump_valid  <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= LOAD;
            pointer     <= '0;
            phase       <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
            load_ready  <= 1'b1;
          end
        end
        LOAD: begin
          if (load_accept) begin
            if (phase == LAST_PH) begin
              phase   <= '0;
              pointer <= pointer + 1'b1;
              if (pointer == LAST_ADDR) begin
                state      <= RUN;
                load_ready <= 1'b0;
                cpu_rst_n  <= 1'b1;
              end
            end else begin
              lo_bytes[8*int'(phase) +: 8] <= load_data;
              phase <= phase + 1'b1;
            end
          end
        end
        RUN: begin
          // Halt has priority over budget expiry; the exit cycle is not counted.
          if (halt || cycle_count == BUDGET_LAST) begin
            state      <= DUMP;
            timeout    <= ~halt;
            cpu_rst_n  <= 1'b0;
            dump_valid <= 1'b1;
            pointer    <= '0;
          end else if (cycle_count != 16'hFFFF) begin
            cycle_count <= cycle_count + 16'd1;
          end
        end
        DUMP: begin
          if (dump_ready) begin
            pointer <= pointer + 1'b1;
            if (pointer == LAST_ADDR) begin
              state      <= DONE;
              dump_valid <= 1'b0;
              done       <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_k_and_s_memory.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_k_and_s_memory : directed bench for the K&S memory harness       |
// | Revision          : 1.0                                             |
// +--------------------------------------------------------------------+
module tb_k_and_s_memory;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_data = '0;
  logic        load_ready;
  logic        cpu_rst_n;
  logic [4:0]  addr = '0;
  logic [15:0] data_in = '0;
  logic        write_enable = 1'b0;
  logic        halt = 1'b0;
  logic [15:0] data_out;
  logic        dump_valid;
  logic        dump_ready = 1'b0;
  logic [4:0]  dump_addr;
  logic [15:0] dump_data;
  logic        done;
  logic        timeout;
  logic [15:0] cycle_count;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int wr_mark;
  int run_cnt;
  logic [15:0] exp_mem [DEPTH];

  k_and_s_memory #(.MAX_CYCLES(20)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_ready   (load_ready),
    .cpu_rst_n    (cpu_rst_n),
    .addr         (addr),
    .data_in      (data_in),
    .write_enable (write_enable),
    .halt         (halt),
    .data_out     (data_out),
    .dump_valid   (dump_valid),
    .dump_ready   (dump_ready),
    .dump_addr    (dump_addr),
    .dump_data    (dump_data),
    .done         (done),
    .timeout      (timeout),
    .cycle_count  (cycle_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (dut.ram_we) wr_count <= wr_count + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [15:0] base);
    for (int i = 0; i < DEPTH; i++) exp_mem[i] = base + 16'(i);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Byte k of the stream is the low (even k) or high (odd k) byte of word k/2.
  task automatic load_bytes(input logic [15:0] base, input int first, input int n, input bit bubbles);
    logic [15:0] val;
    for (int k = first; k < first + n; k++) begin
      if (bubbles) begin
        load_valid = 1'b0;
        tick();
      end
      val        = base + 16'(k / 2);
      load_valid = 1'b1;
      load_data  = (k % 2 == 1) ? val[15:8] : val[7:0];
      tick();
    end
    load_valid = 1'b0;
  endtask

  task automatic dump_check(input string tag, input int stall_addr);
    int idx = 0;
    int stalls = 0;
    int cyc = 0;
    while (idx < DEPTH && cyc < 400) begin
      if (dump_valid && int'(dump_addr) == stall_addr && stalls < 5) begin
        dump_ready = 1'b0;
        check({tag, " stall addr"}, dump_addr, stall_addr);
        check({tag, " stall data"}, dump_data, exp_mem[stall_addr]);
        stalls++;
      end else begin
        dump_ready = 1'b1;
      end
      #1;
      if (dump_valid && dump_ready) begin
        check({tag, " addr"}, dump_addr, idx);
        check({tag, " data"}, dump_data, exp_mem[idx]);
        idx++;
      end
      tick();
      cyc++;
    end
    dump_ready = 1'b0;
    check({tag, " word count"}, idx, DEPTH);
    check({tag, " done"}, done, 1'b1);
    check({tag, " valid low"}, dump_valid, 1'b0);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("reset cpu_rst_n", cpu_rst_n, 1'b0);
    check("reset load_ready", load_ready, 1'b0);
    check("reset dump_valid", dump_valid, 1'b0);
    check("reset dump_addr", dump_addr, 5'd0);
    check("reset done", done, 1'b0);
    check("reset timeout", timeout, 1'b0);
    check("reset cycle_count", cycle_count, 16'd0);

    // Test 1: clean load, RUN write, halt, dump with a stall on word 10.
    pulse_start();
    check("t1 load_ready up", load_ready, 1'b1);
    wr_mark = wr_count;
    load_bytes(16'hA500, 0, 64, 1'b0);
    set_exp(16'hA500);
    check("t1 load_ready dropped", load_ready, 1'b0);
    check("t1 cpu_rst_n up", cpu_rst_n, 1'b1);
    check("t1 write count", wr_count - wr_mark, 32);
    check("t1 cycle_count first", cycle_count, 16'd0);
    addr = 5'd7;
    #1;
    check("t1 read addr7", data_out, 16'hA507);
    addr = 5'd3;
    data_in = 16'h1234;
    write_enable = 1'b1;
    #1;
    check("t1 read old on write", data_out, 16'hA503);
    tick();
    write_enable = 1'b0;
    #1;
    check("t1 read after write", data_out, 16'h1234);
    exp_mem[3] = 16'h1234;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("t1 dump_valid", dump_valid, 1'b1);
    check("t1 cpu_rst_n dump", cpu_rst_n, 1'b0);
    dump_check("t1 dump", 10);
    check("t1 timeout", timeout, 1'b0);

    // Test 2: bubbled load, odd byte count holds in LOAD.
    pulse_start();
    check("t2 done cleared", done, 1'b0);
    check("t2 cycle_count cleared", cycle_count, 16'd0);
    wr_mark = wr_count;
    load_bytes(16'hA500, 0, 63, 1'b1);
    repeat (5) tick();
    check("t2 odd still reset", cpu_rst_n, 1'b0);
    check("t2 odd load_ready", load_ready, 1'b1);
    check("t2 odd write count", wr_count - wr_mark, 31);
    load_bytes(16'hA500, 63, 1, 1'b1);
    check("t2 cpu_rst_n up", cpu_rst_n, 1'b1);
    check("t2 write count", wr_count - wr_mark, 32);
    set_exp(16'hA500);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    dump_check("t2 dump", -1);
    check("t2 timeout", timeout, 1'b0);

    // Test 3: budget timeout after 20 RUN cycles; start ignored in DUMP.
    pulse_start();
    load_bytes(16'h5A00, 0, 64, 1'b0);
    set_exp(16'h5A00);
    run_cnt = 0;
    while (!dump_valid && run_cnt < 100) begin
      tick();
      run_cnt++;
    end
    check("t3 run cycles", run_cnt, 20);
    check("t3 cycle_count", cycle_count, 16'd19);
    check("t3 timeout", timeout, 1'b1);
    check("t3 cpu_rst_n", cpu_rst_n, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t3 start in dump valid", dump_valid, 1'b1);
    check("t3 start in dump addr", dump_addr, 5'd0);
    check("t3 start in dump load_ready", load_ready, 1'b0);
    dump_check("t3 dump", -1);
    check("t3 timeout held", timeout, 1'b1);
    check("t3 cycle_count held", cycle_count, 16'd19);

    // Test 4: halt on the budget cycle wins; start ignored in RUN; DUMP ignores writes.
    pulse_start();
    check("t4 cycle_count cleared", cycle_count, 16'd0);
    check("t4 timeout cleared", timeout, 1'b0);
    load_bytes(16'h0F00, 0, 64, 1'b0);
    set_exp(16'h0F00);
    for (int k = 0; k < 19; k++) begin
      start = (k == 5);
      tick();
    end
    start = 1'b0;
    check("t4 start in run load_ready", load_ready, 1'b0);
    check("t4 start in run cpu_rst_n", cpu_rst_n, 1'b1);
    check("t4 budget cycle count", cycle_count, 16'd19);
    halt = 1'b1;
    tick();
    halt = 1'b0;
    check("t4 dump entered", dump_valid, 1'b1);
    check("t4 timeout", timeout, 1'b0);
    addr = 5'd0;
    data_in = 16'hFFFF;
    write_enable = 1'b1;
    dump_check("t4 dump", -1);
    write_enable = 1'b0;

    // Test 5: reset mid-load, retention, full reload, halt-cycle write.
    pulse_start();
    load_bytes(16'h3300, 0, 20, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5 rst load_ready", load_ready, 1'b0);
    check("t5 rst cpu_rst_n", cpu_rst_n, 1'b0);
    check("t5 rst dump_valid", dump_valid, 1'b0);
    addr = 5'd2;
    #1;
    check("t5 retained word", data_out, 16'h3302);
    pulse_start();
    addr = 5'd4;
    data_in = 16'h0000;
    write_enable = 1'b1;
    load_bytes(16'hC300, 0, 64, 1'b0);
    write_enable = 1'b0;
    set_exp(16'hC300);
    addr = 5'd31;
    data_in = 16'hBEEF;
    write_enable = 1'b1;
    halt = 1'b1;
    tick();
    halt = 1'b0;
    write_enable = 1'b0;
    exp_mem[31] = 16'hBEEF;
    dump_check("t5 dump", -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
